// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the UART transmit-side FIFO.
package uart_pkg;

   localparam int UART_DATA_W      = 8;
   localparam int UART_DEPTH       = 16;
   localparam int UART_ACK_TIMEOUT = 1023;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_LOAD      = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_DONE = 2'd3
   } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; full/empty are decoded from count.
module sync_fifo
   import uart_pkg::*;
#(
   parameter int WIDTH = UART_DATA_W,
   parameter int DEPTH = UART_DEPTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wr_en,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd_en,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_ok;
   logic             rd_ok;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   // A write while full is dropped even if a pop happens in the same cycle.
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte queue in front of a UART transmitter: pops one byte at a time, requests a
// transmission and gives up on a byte if the transmitter never acknowledges it.
module uart_tx_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH       = UART_DEPTH,
   parameter int ACK_TIMEOUT = UART_ACK_TIMEOUT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             wr_data,
   input  logic                   wr_en,
   input  logic                   tx_busy,
   input  logic                   clr_flags,
   output logic [7:0]             tx_data,
   output logic                   transmit,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output logic                   overflow,
   output logic                   ack_timeout,
   output uart_state_e            state
);

   localparam int TW = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LIMIT = TW'(ACK_TIMEOUT);

   // Handshake: transmit is the request and stays high with tx_data stable until
   // the transmitter answers with tx_busy=1; the byte is then owned by the UART
   // and the next pop waits for tx_busy to fall again.
   uart_state_e   state_q;
   uart_state_e   state_d;
   logic          pop;
   logic          to_event;
   logic [7:0]    fifo_head;
   logic [TW-1:0] to_cnt;

   assign state = state_q;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (fifo_head),
      .full    (full),
      .empty   (empty),
      .count   (count)
   );

   always_comb begin
      state_d  = state_q;
      pop      = 1'b0;
      to_event = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!empty && !tx_busy) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            pop     = 1'b1;
            state_d = ST_WAIT_BUSY;
         end
         ST_WAIT_BUSY: begin
            if (tx_busy) begin
               state_d = ST_WAIT_DONE;
            end else if (to_cnt == TO_LIMIT) begin
               to_event = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         ST_WAIT_DONE: begin
            if (!tx_busy) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         transmit <= 1'b0;
         tx_data  <= 8'h00;
         to_cnt   <= '0;
      end else begin
         state_q  <= state_d;
         transmit <= (state_d == ST_WAIT_BUSY);
         if (pop) tx_data <= fifo_head;
         // Counter restarts on every entry to WAIT_BUSY and stops at the limit.
         if (state_q != ST_WAIT_BUSY) begin
            to_cnt <= '0;
         end else if (to_cnt != TO_LIMIT) begin
            to_cnt <= to_cnt + 1'b1;
         end
      end
   end

   // Sticky flags: a set event in the same cycle as clr_flags wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow    <= 1'b0;
         ack_timeout <= 1'b0;
      end else begin
         if (wr_en && full)  overflow <= 1'b1;
         else if (clr_flags) overflow <= 1'b0;
         if (to_event)       ack_timeout <= 1'b1;
         else if (clr_flags) ack_timeout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo with a behavioural UART responder and byte scoreboard.
module tb_uart_tx_fifo;
   import uart_pkg::*;

   localparam int DEPTH       = 16;
   localparam int ACK_TIMEOUT = 1023;
   localparam int CW          = $clog2(DEPTH) + 1;

   // clock / reset
   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [7:0]  wr_data   = 8'h00;
   logic        wr_en     = 1'b0;
   logic        tx_busy   = 1'b0;
   logic        clr_flags = 1'b0;
   logic [7:0]  tx_data;
   logic        transmit;
   logic        full;
   logic        empty;
   logic [CW-1:0] count;
   logic        overflow;
   logic        ack_timeout;
   uart_state_e state;

   uart_tx_fifo #(
      .DEPTH       (DEPTH),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_data     (wr_data),
      .wr_en       (wr_en),
      .tx_busy     (tx_busy),
      .clr_flags   (clr_flags),
      .tx_data     (tx_data),
      .transmit    (transmit),
      .full        (full),
      .empty       (empty),
      .count       (count),
      .overflow    (overflow),
      .ack_timeout (ack_timeout),
      .state       (state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // scoreboard: bytes accepted by the FIFO, in the order the UART must see them
   logic [7:0] exp_q[$];
   int         n_captured = 0;

   // behavioural UART transmitter model
   bit resp_on   = 1'b0;
   int busy_left = 0;
   int ack_wait  = 0;
   int busy_min  = 1;
   int busy_max  = 1;
   int ack_max   = 0;

   task automatic resp_setup(input int bmin, input int bmax, input int amax);
      busy_min  = bmin;
      busy_max  = bmax;
      ack_max   = amax;
      busy_left = 0;
      ack_wait  = int'($urandom_range(amax, 0));
      tx_busy   = 1'b0;
      resp_on   = 1'b1;
   endtask

   // One clock: advance to just after the rising edge, then let the UART model react.
   task automatic step();
      logic [7:0] exp_b;
      @(posedge clk);
      #1;
      if (resp_on) begin
         if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
         end else if (transmit && !tx_busy) begin
            if (ack_wait > 0) begin
               ack_wait--;
            end else begin
               n_checks++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL sb_extra_byte: got tx_data=%h, expected no byte", tx_data);
               end else begin
                  exp_b = exp_q.pop_front();
                  if (tx_data !== exp_b) begin
                     n_fail++;
                     $display("FAIL sb_order: got tx_data=%h, expected %h", tx_data, exp_b);
                  end
               end
               n_captured++;
               tx_busy   = 1'b1;
               busy_left = int'($urandom_range(busy_max, busy_min));
               ack_wait  = int'($urandom_range(ack_max, 0));
            end
         end
      end
   endtask

   task automatic apply_reset();
      resp_on   = 1'b0;
      tx_busy   = 1'b0;
      wr_en     = 1'b0;
      clr_flags = 1'b0;
      reset     = 1'b1;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic drain(input string tag);
      int i = 0;
      while ((exp_q.size() != 0 || state != ST_IDLE || tx_busy) && i < 3000) begin
         step();
         i++;
      end
      n_checks++;
      if (exp_q.size() != 0 || state != ST_IDLE) begin
         n_fail++;
         $display("FAIL drain_%s: got %0d bytes pending state=%0d, expected 0 pending state=0", tag, exp_q.size(), state);
      end
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks++; if (transmit !== 1'b0)    begin n_fail++; $display("FAIL rst_transmit: got %b expected 0", transmit); end
      n_checks++; if (tx_data !== 8'h00)    begin n_fail++; $display("FAIL rst_tx_data: got %h expected 00", tx_data); end
      n_checks++; if (count !== CW'(0))     begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
      n_checks++; if (empty !== 1'b1)       begin n_fail++; $display("FAIL rst_empty: got %b expected 1", empty); end
      n_checks++; if (full !== 1'b0)        begin n_fail++; $display("FAIL rst_full: got %b expected 0", full); end
      n_checks++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
      n_checks++; if (ack_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_ack_timeout: got %b expected 0", ack_timeout); end
      n_checks++; if (state !== ST_IDLE)    begin n_fail++; $display("FAIL rst_state: got %0d expected 0", state); end
   endtask

   task automatic test_single();
      int cap0;
      resp_setup(4, 4, 0);
      cap0 = n_captured;
      exp_q.push_back(8'hA5);
      wr_data = 8'hA5; wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      n_checks++; if (count !== CW'(1))  begin n_fail++; $display("FAIL single_count_write: got %0d expected 1", count); end
      n_checks++; if (transmit !== 1'b0) begin n_fail++; $display("FAIL single_tx_edge1: got %b expected 0", transmit); end
      step();
      n_checks++; if (transmit !== 1'b0) begin n_fail++; $display("FAIL single_tx_edge2: got %b expected 0", transmit); end
      n_checks++; if (state !== ST_LOAD) begin n_fail++; $display("FAIL single_state_load: got %0d expected 1", state); end
      step();
      n_checks++; if (transmit !== 1'b1) begin n_fail++; $display("FAIL single_tx_edge3: got %b expected 1", transmit); end
      n_checks++; if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_tx_data: got %h expected a5", tx_data); end
      step();
      n_checks++; if (transmit !== 1'b0) begin n_fail++; $display("FAIL single_tx_after_busy: got %b expected 0", transmit); end
      drain("single");
      n_checks++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL single_empty: got %b expected 1", empty); end
      n_checks++; if (n_captured - cap0 != 1) begin n_fail++; $display("FAIL single_captured: got %0d expected 1", n_captured - cap0); end
   endtask

   task automatic test_overflow();
      int cap0;
      resp_on = 1'b0;
      tx_busy = 1'b1;
      for (int i = 1; i <= DEPTH; i++) begin
         exp_q.push_back(8'(i));
         wr_data = 8'(i); wr_en = 1'b1;
         step();
      end
      wr_en = 1'b0;
      n_checks++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_count_full: got %0d expected %0d", count, DEPTH); end
      n_checks++; if (full !== 1'b1)        begin n_fail++; $display("FAIL ovf_full: got %b expected 1", full); end
      n_checks++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL ovf_not_yet: got %b expected 0", overflow); end
      n_checks++; if (transmit !== 1'b0 || state !== ST_IDLE) begin n_fail++; $display("FAIL ovf_busy_no_pop: got transmit=%b state=%0d expected 0/0", transmit, state); end
      wr_data = 8'hFF; wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      n_checks++; if (overflow !== 1'b1)    begin n_fail++; $display("FAIL ovf_set: got %b expected 1", overflow); end
      n_checks++; if (count !== CW'(DEPTH)) begin n_fail++; $display("FAIL ovf_count_held: got %0d expected %0d", count, DEPTH); end
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      n_checks++; if (overflow !== 1'b0)    begin n_fail++; $display("FAIL ovf_clear: got %b expected 0", overflow); end
      wr_data = 8'hEE; wr_en = 1'b1; clr_flags = 1'b1;
      step();
      wr_en = 1'b0; clr_flags = 1'b0;
      n_checks++; if (overflow !== 1'b1)    begin n_fail++; $display("FAIL ovf_set_wins: got %b expected 1", overflow); end
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      cap0 = n_captured;
      resp_setup(2, 6, 2);
      drain("ovf");
      n_checks++; if (n_captured - cap0 != DEPTH) begin n_fail++; $display("FAIL ovf_captured: got %0d expected %0d", n_captured - cap0, DEPTH); end
      n_checks++; if (count !== CW'(0) || empty !== 1'b1) begin n_fail++; $display("FAIL ovf_drained: got count=%0d empty=%b expected 0/1", count, empty); end
   endtask

   task automatic test_timeout();
      int total = 0;
      int n_tx  = 0;
      bit early = 1'b0;
      bit rerise = 1'b0;
      resp_on = 1'b0;
      tx_busy = 1'b0;
      wr_data = 8'h3C; wr_en = 1'b1;
      step(); total++;
      wr_en = 1'b0;
      while (!transmit && total < 10) begin step(); total++; end
      while (transmit && total < 1100) begin
         n_tx++;
         if (ack_timeout) early = 1'b1;
         step(); total++;
      end
      n_checks++; if (n_tx != ACK_TIMEOUT + 1) begin n_fail++; $display("FAIL to_wait_cycles: got %0d expected %0d", n_tx, ACK_TIMEOUT + 1); end
      n_checks++; if (early !== 1'b0)       begin n_fail++; $display("FAIL to_early_flag: got %b expected 0", early); end
      n_checks++; if (ack_timeout !== 1'b1) begin n_fail++; $display("FAIL to_flag: got %b expected 1", ack_timeout); end
      n_checks++; if (state !== ST_IDLE)    begin n_fail++; $display("FAIL to_state_idle: got %0d expected 0", state); end
      while (total < 1100) begin
         if (transmit) rerise = 1'b1;
         step(); total++;
      end
      n_checks++; if (rerise !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL to_discarded: got rerise=%b empty=%b expected 0/1", rerise, empty); end
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      n_checks++; if (ack_timeout !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %b expected 0", ack_timeout); end
   endtask

   task automatic test_reset_mid();
      int i = 0;
      int pulses = 0;
      resp_setup(200, 200, 0);
      for (int k = 0; k < 6; k++) begin
         wr_data = 8'(8'h50 + k); exp_q.push_back(8'(8'h50 + k)); wr_en = 1'b1;
         step();
      end
      wr_en = 1'b0;
      while (!(state == ST_WAIT_DONE && count == CW'(5)) && i < 50) begin step(); i++; end
      n_checks++; if (state !== ST_WAIT_DONE || count !== CW'(5)) begin n_fail++; $display("FAIL rmid_setup: got state=%0d count=%0d expected 3/5", state, count); end
      #3 reset = 1'b1;
      #1;
      n_checks++; if (transmit !== 1'b0 || count !== CW'(0) || empty !== 1'b1) begin n_fail++; $display("FAIL rmid_async: got transmit=%b count=%0d empty=%b expected 0/0/1", transmit, count, empty); end
      n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL rmid_state: got %0d expected 0", state); end
      resp_on = 1'b0; tx_busy = 1'b0; exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (50) begin step(); if (transmit) pulses++; end
      n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rmid_no_pulses: got %0d expected 0", pulses); end
      // reset while the request is still pending must drop transmit at once
      wr_data = 8'h5A; wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      i = 0;
      while (!transmit && i < 10) begin step(); i++; end
      n_checks++; if (transmit !== 1'b1) begin n_fail++; $display("FAIL rbusy_setup: got %b expected 1", transmit); end
      #3 reset = 1'b1;
      #1;
      n_checks++; if (transmit !== 1'b0 || tx_data !== 8'h00) begin n_fail++; $display("FAIL rbusy_async: got transmit=%b tx_data=%h expected 0/00", transmit, tx_data); end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_back_to_back();
      resp_on = 1'b0;
      tx_busy = 1'b1;
      foreach (exp_q[j]) exp_q.delete(j);
      for (int k = 0; k < 3; k++) begin
         wr_data = 8'(8'h11 * (k + 1)); exp_q.push_back(8'(8'h11 * (k + 1))); wr_en = 1'b1;
         step();
      end
      wr_en = 1'b0;
      n_checks++; if (count !== CW'(3)) begin n_fail++; $display("FAIL b2b_count3: got %0d expected 3", count); end
      resp_setup(3, 6, 1);
      step();
      n_checks++; if (state !== ST_LOAD) begin n_fail++; $display("FAIL b2b_load: got %0d expected 1", state); end
      wr_data = 8'h44; exp_q.push_back(8'h44); wr_en = 1'b1;
      step();
      wr_en = 1'b0;
      n_checks++; if (count !== CW'(3)) begin n_fail++; $display("FAIL b2b_same_cycle: got %0d expected 3", count); end
      drain("b2b");
   endtask

   task automatic test_random();
      logic [7:0] b;
      resp_setup(1, 12, 3);
      repeat (400) begin
         if ($urandom_range(1, 0) == 1 && exp_q.size() < DEPTH) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            wr_data = b; wr_en = 1'b1;
         end else begin
            wr_en = 1'b0;
         end
         step();
      end
      wr_en = 1'b0;
      drain("rand");
      n_checks++; if (count !== CW'(0) || empty !== 1'b1) begin n_fail++; $display("FAIL rand_final: got count=%0d empty=%b expected 0/1", count, empty); end
      n_checks++; if (overflow !== 1'b0 || ack_timeout !== 1'b0) begin n_fail++; $display("FAIL rand_flags: got ovf=%b to=%b expected 0/0", overflow, ack_timeout); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_overflow();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
